// File: rtl/mem_wb_writeback.sv
// ============================================================================
// mem_wb_writeback
// ----------------------------------------------------------------------------
// MEM/WB pipeline register and write-back stage of the 5-stage MIPS32 pipe.
//
// The MEM-stage control bits, ALU result and destination register are
// registered here. The load data arrives on mem_data_WB_in one cycle later,
// so it lines up with the registered control. If WB stalls, the load data is
// frozen into a local buffer because MEM may overwrite its output while WB
// is held. The stage drives the register-file write port, gives a one-cycle
// delayed copy of each write for WB->ID bypass, and keeps saturating retire
// and stall counters.
//
// Ports
//   clk, rst_n             clock; asynchronous active-low reset
//   valid_WB_in            instruction from MEM is real (not a bubble)
//   stall_WB_in            hold the WB stage contents
//   flush_WB_in            replace the next WB contents with a bubble
//   MemtoReg_WB_in         write back load data (1) or ALU result (0)
//   RegWrite_WB_in         instruction writes the register file
//   address_WB_in          ALU result / memory address
//   mem_data_WB_in         load data, valid in the cycle the load is in WB
//   rd_WB_in               destination register
//   reg_write_*_out        register-file write port (combinational)
//   prev_write_*_out       last cycle's write port values, for bypass
//   retired_count_out      retired valid instructions (saturating)
//   stall_count_out        stalled cycles with a valid instruction in WB
// ============================================================================
module mem_wb_writeback #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_WB_in,
    input  logic                   stall_WB_in,
    input  logic                   flush_WB_in,
    input  logic                   MemtoReg_WB_in,
    input  logic                   RegWrite_WB_in,
    input  logic [31:0]            address_WB_in,
    input  logic [31:0]            mem_data_WB_in,
    input  logic [4:0]             rd_WB_in,
    output logic                   reg_write_en_out,
    output logic [4:0]             reg_write_addr_out,
    output logic [31:0]            reg_write_data_out,
    output logic                   prev_write_en_out,
    output logic [4:0]             prev_write_addr_out,
    output logic [31:0]            prev_write_data_out,
    output logic [COUNT_WIDTH-1:0] retired_count_out,
    output logic [COUNT_WIDTH-1:0] stall_count_out
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    logic        valid_q;
    logic        mem_to_reg_q;
    logic        reg_write_q;
    logic [31:0] alu_q;
    logic [4:0]  rd_q;
    logic        held_q;
    logic [31:0] hold_data;

    logic        retire;
    logic [31:0] load_data;

    // ------------------------------------------------------------------------
    // Stage register. Priority: reset > flush > stall > load.
    // ------------------------------------------------------------------------
    // NOTE: every register here is a plain flop (no memory array), so each one
    // gets an explicit reset value; non-blocking assignments keep all flops
    // sampling the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_q        <= 32'd0;
            rd_q         <= 5'd0;
            held_q       <= 1'b0;
            hold_data    <= 32'd0;
        end else if (flush_WB_in) begin
            // Remaining fields are don't-care once the slot is a bubble.
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else if (stall_WB_in) begin
            // Freeze the load data on the first stalled edge only; later
            // stalled edges keep the captured copy.
            if (valid_q && !held_q) begin
                hold_data <= mem_data_WB_in;
                held_q    <= 1'b1;
            end
        end else begin
            valid_q      <= valid_WB_in;
            mem_to_reg_q <= MemtoReg_WB_in;
            reg_write_q  <= RegWrite_WB_in;
            alu_q        <= address_WB_in;
            rd_q         <= rd_WB_in;
            held_q       <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Write-back select and register-file write port.
    // ------------------------------------------------------------------------
    // NOTE: every output of this block is assigned on every path (continuous
    // expressions, no incomplete if/case), so no latch can be inferred.
    always_comb begin
        retire             = valid_q & ~stall_WB_in;
        load_data          = held_q ? hold_data : mem_data_WB_in;
        reg_write_data_out = mem_to_reg_q ? load_data : alu_q;
        reg_write_addr_out = rd_q;
        // r0 is hard-wired to zero, so writes to it are dropped here.
        reg_write_en_out   = retire & reg_write_q & (rd_q != 5'd0);
    end

    // ------------------------------------------------------------------------
    // Bypass copy: captured on every edge, independent of stall/flush.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_write_en_out   <= 1'b0;
            prev_write_addr_out <= 5'd0;
            prev_write_data_out <= 32'd0;
        end else begin
            prev_write_en_out   <= reg_write_en_out;
            prev_write_addr_out <= reg_write_addr_out;
            prev_write_data_out <= reg_write_data_out;
        end
    end

    // ------------------------------------------------------------------------
    // Saturating counters: stick at all-ones instead of wrapping.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_count_out <= '0;
            stall_count_out   <= '0;
        end else begin
            if (retire && (retired_count_out != '1)) begin
                retired_count_out <= retired_count_out + COUNT_ONE;
            end
            if (valid_q && stall_WB_in && (stall_count_out != '1)) begin
                stall_count_out <= stall_count_out + COUNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// ============================================================================
// tb_mem_wb_writeback
// ----------------------------------------------------------------------------
// Self-checking bench for mem_wb_writeback. A reference model tracks "the
// instruction sitting in WB" (plus its frozen load value while stalled) and
// the expected counters. A compare process checks every negedge against the
// model. Directed sequences add hand-computed literal expectations, followed
// by a randomized phase. The counters are 4 bits wide so saturation is
// reached within the run.
// ============================================================================
module tb_mem_wb_writeback;

    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk;
    logic          rst_n;
    logic          valid_in, stall_in, flush_in, mtr_in, rw_in;
    logic [31:0]   addr_in, mdata_in;
    logic [4:0]    rd_in;
    logic          en, pen;
    logic [4:0]    waddr, paddr;
    logic [31:0]   wdata, pdata;
    logic [CW-1:0] ret_cnt, stl_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mem_wb_writeback #(.COUNT_WIDTH(CW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .valid_WB_in         (valid_in),
        .stall_WB_in         (stall_in),
        .flush_WB_in         (flush_in),
        .MemtoReg_WB_in      (mtr_in),
        .RegWrite_WB_in      (rw_in),
        .address_WB_in       (addr_in),
        .mem_data_WB_in      (mdata_in),
        .rd_WB_in            (rd_in),
        .reg_write_en_out    (en),
        .reg_write_addr_out  (waddr),
        .reg_write_data_out  (wdata),
        .prev_write_en_out   (pen),
        .prev_write_addr_out (paddr),
        .prev_write_data_out (pdata),
        .retired_count_out   (ret_cnt),
        .stall_count_out     (stl_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: the instruction occupying WB.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic        valid;
        logic        from_mem;
        logic        writes;
        logic [31:0] alu;
        logic [4:0]  rd;
    } instr_t;

    instr_t      wb;
    logic        frozen;
    logic [31:0] frozen_val;
    int          m_ret, m_stl;
    logic        m_pen;
    logic [4:0]  m_paddr;
    logic [31:0] m_pdata;

    logic        x_en;
    logic [31:0] x_data;

    always_comb begin
        x_en   = wb.valid && !stall_in && wb.writes && (wb.rd != 5'd0);
        x_data = wb.from_mem ? (frozen ? frozen_val : mdata_in) : wb.alu;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb         <= '0;
            frozen     <= 1'b0;
            frozen_val <= 32'd0;
            m_ret      <= 0;
            m_stl      <= 0;
            m_pen      <= 1'b0;
            m_paddr    <= 5'd0;
            m_pdata    <= 32'd0;
        end else begin
            m_pen   <= x_en;
            m_paddr <= wb.rd;
            m_pdata <= x_data;
            if (wb.valid && !stall_in) m_ret <= (m_ret < int'(CMAX)) ? m_ret + 1 : m_ret;
            if (wb.valid && stall_in)  m_stl <= (m_stl < int'(CMAX)) ? m_stl + 1 : m_stl;
            if (flush_in) begin
                wb.valid <= 1'b0;
                frozen   <= 1'b0;
            end else if (stall_in) begin
                if (wb.valid && !frozen) begin
                    frozen     <= 1'b1;
                    frozen_val <= mdata_in;
                end
            end else begin
                wb     <= '{valid: valid_in, from_mem: mtr_in, writes: rw_in,
                            alu: addr_in, rd: rd_in};
                frozen <= 1'b0;
            end
        end
    end

    // Compare process: write address/data only matter when a write is due.
    always @(negedge clk) begin
        if (rst_n) begin
            check("m_en", 32'(en), 32'(x_en));
            if (x_en) begin
                check("m_addr", 32'(waddr), 32'(wb.rd));
                check("m_data", wdata, x_data);
            end
            check("m_prev_en", 32'(pen), 32'(m_pen));
            if (m_pen) begin
                check("m_prev_addr", 32'(paddr), 32'(m_paddr));
                check("m_prev_data", pdata, m_pdata);
            end
            check("m_retired", 32'(ret_cnt), 32'(m_ret));
            check("m_stalls", 32'(stl_cnt), 32'(m_stl));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic f, input logic m,
                         input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd);
        valid_in = v; stall_in = s; flush_in = f; mtr_in = m;
        rw_in = r; addr_in = a; mdata_in = d; rd_in = rd;
    endtask

    task automatic bubble(input logic [31:0] d);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_0000, d, 5'd31);
    endtask

    initial begin
        rst_n = 1'b0;
        bubble(32'd0);
        tick();
        tick();
        // Reset state
        check("rst_en", 32'(en), 32'd0);
        check("rst_addr", 32'(waddr), 32'd0);
        check("rst_data", wdata, 32'd0);
        check("rst_prev_en", 32'(pen), 32'd0);
        check("rst_retired", 32'(ret_cnt), 32'd0);
        check("rst_stalls", 32'(stl_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // ALU write to r5
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0, 5'd5);
        tick();
        bubble(32'h0);
        #1;
        check("alu_en", 32'(en), 32'd1);
        check("alu_addr", 32'(waddr), 32'd5);
        check("alu_data", wdata, 32'h0000_1234);
        tick();
        check("alu_prev_en", 32'(pen), 32'd1);
        check("alu_prev_addr", 32'(paddr), 32'd5);
        check("alu_prev_data", pdata, 32'h0000_1234);
        check("alu_retired", 32'(ret_cnt), 32'd1);

        // Load to r8: data arrives while the load is in WB
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0, 5'd8);
        tick();
        bubble(32'hDEAD_BEEF);
        #1;
        check("ld_en", 32'(en), 32'd1);
        check("ld_addr", 32'(waddr), 32'd8);
        check("ld_data", wdata, 32'hDEAD_BEEF);

        // Write to r0 is suppressed but still retires
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0055, 32'h0, 5'd0);
        tick();
        bubble(32'h0);
        #1;
        check("r0_en", 32'(en), 32'd0);
        tick();
        check("r0_retired", 32'(ret_cnt), 32'd3);

        // Three-cycle stall on a load to r9; MEM data changes mid-stall
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 5'd9);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hA5A5_A5A5, 5'd0);
        #1;
        check("stl_en_c1", 32'(en), 32'd0);
        tick();
        mdata_in = 32'h0;
        #1;
        check("stl_en_c2", 32'(en), 32'd0);
        tick();
        check("stl_en_c3", 32'(en), 32'd0);
        tick();
        stall_in = 1'b0;
        #1;
        check("stl_en_rel", 32'(en), 32'd1);
        check("stl_addr", 32'(waddr), 32'd9);
        check("stl_data", wdata, 32'hA5A5_A5A5);
        check("stl_count", 32'(stl_cnt), 32'd3);
        tick();
        check("stl_retired", 32'(ret_cnt), 32'd4);

        // Flush and stall together discard the WB instruction
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0077, 32'h0, 5'd3);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        check("fl_en", 32'(en), 32'd0);
        tick();
        bubble(32'h0);
        #1;
        check("fl_en_after", 32'(en), 32'd0);
        tick();
        check("fl_retired", 32'(ret_cnt), 32'd4);

        // Reset while a load is held in a stall: clears without a clock edge
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0099, 32'h0, 5'd10);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1111_1111, 5'd0);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_en", 32'(en), 32'd0);
        check("ar_addr", 32'(waddr), 32'd0);
        check("ar_data", wdata, 32'd0);
        check("ar_prev_en", 32'(pen), 32'd0);
        check("ar_retired", 32'(ret_cnt), 32'd0);
        check("ar_stalls", 32'(stl_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        stall_in = 1'b0;
        #1;
        check("ar_empty", 32'(en), 32'd0);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            tick();
            valid_in = ($urandom_range(0, 3) != 0);
            stall_in = ($urandom_range(0, 9) < 3);
            flush_in = ($urandom_range(0, 9) == 0);
            mtr_in   = $urandom_range(0, 1);
            rw_in    = ($urandom_range(0, 4) != 0);
            addr_in  = $urandom;
            mdata_in = $urandom;
            rd_in    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        end
        tick();
        bubble(32'h0);
        #1;
        check("sat_retired", 32'(ret_cnt), 32'(CMAX));
        check("sat_stalls", 32'(stl_cnt), 32'(CMAX));
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_writeback.md
# mem_wb_writeback

MEM/WB pipeline register plus write-back stage of the 5-stage MIPS32 pipeline, sitting directly downstream of the memory access stage. It aligns the MEM-stage control bits, ALU result and destination register with the load data, which the memory stage delivers one clock later. It selects the write-back value, drives the register-file write port, and provides a one-cycle-delayed copy of the write for WB→ID bypass. It also supports pipeline stall and flush and keeps saturating retire and stall counters.

## Interface
Parameters:
- COUNT_WIDTH, 32, width of the retire and stall counters

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_WB_in  in  1  the instruction presented by MEM is real (not a bubble)
- stall_WB_in  in  1  hold the WB stage contents
- flush_WB_in  in  1  replace the next WB contents with a bubble
- MemtoReg_WB_in  in  1  select load data (1) or ALU result (0)
- RegWrite_WB_in  in  1  instruction writes the register file
- address_WB_in  in  32  ALU result / memory address from MEM
- mem_data_WB_in  in  32  load data from MEM, registered there, valid the cycle after the load is in MEM
- rd_WB_in  in  5  destination register
- reg_write_en_out  out  1  register-file write enable
- reg_write_addr_out  out  5  register-file write address
- reg_write_data_out  out  32  register-file write data
- prev_write_en_out  out  1  previous cycle's write enable, for WB→ID bypass
- prev_write_addr_out  out  5  previous cycle's write address
- prev_write_data_out  out  32  previous cycle's write data
- retired_count_out  out  COUNT_WIDTH  number of retired valid instructions
- stall_count_out  out  COUNT_WIDTH  number of stalled cycles with a valid instruction in WB

## Operation
- Stage registers: valid_q, MemtoReg_q, RegWrite_q, alu_q[31:0], rd_q[4:0], held_q, hold_data[31:0].
- Update priority at each edge: reset > flush > stall > load.
  - Flush: valid_q<=0 and held_q<=0; other registers are don't-care.
  - Stall without flush: all stage registers hold.
  - Load: capture the *_WB_in values and valid_WB_in; held_q<=0.
- Load-data hold, needed because MEM may overwrite mem_data_WB_in while WB is stalled:
  - At an edge with stall=1, flush=0, valid_q=1 and held_q=0: hold_data<=mem_data_WB_in and held_q<=1.
  - held_q clears at any edge with stall=0 or flush=1.
- Load data value: ld = held_q ? hold_data : mem_data_WB_in.
- Write-back data: reg_write_data_out = MemtoReg_q ? ld : alu_q. This is combinational from the registers and the live input.
- Retire condition: retire = valid_q & ~stall_WB_in.
- reg_write_en_out = retire & RegWrite_q & (rd_q != 0). Writes to r0 are always suppressed.
- reg_write_addr_out = rd_q.
- prev_write_*: registered copy of reg_write_{en,addr,data}_out, captured at every edge regardless of stall or flush.
- Counters:
  - retired_count_out increments at an edge where retire=1.
  - stall_count_out increments at an edge where valid_q & stall_WB_in.
  - Both saturate at all-ones and never wrap.
- Flush and stall both high: flush wins. The WB instruction does not retire in that cycle, because stall is high, and it is discarded.

## Timing
- Reset (rst_n=0, asynchronous): all stage registers, prev_write_*, held_q and both counters go to 0.
  - Consequences: reg_write_en_out=0, reg_write_addr_out=0, reg_write_data_out = alu_q = 0, prev_write_en_out=0.
- Reset asserted mid-stall or mid-hold: held data is lost and no write occurs. After release, the stage is empty until the first load edge.
- Latency: an instruction present at the MEM inputs in cycle N is in WB during cycle N+1.
  - Its write is asserted combinationally in cycle N+1, if not stalled, and lands in the register file at the end of N+1.
  - The load data arriving on mem_data_WB_in in cycle N+1 is the data used.
- prev_write_* reflect cycle N+1's write during cycle N+2.
- Stall of k cycles on a valid instruction:
  - reg_write_en_out stays 0 for k cycles, then is 1 for exactly one cycle.
  - The instruction is counted once in retired_count_out, and stall_count_out increases by k.
- Back-to-back unstalled valid instructions retire one per cycle.

## Test plan
- ALU write: valid=1, RegWrite=1, MemtoReg=0, address=0x0000_1234, rd=5 → next cycle en=1, addr=5, data=0x1234; the cycle after, prev_en=1 with the same addr/data; retired=1.
- Load: MemtoReg=1, rd=8, mem_data=0xDEAD_BEEF in the WB cycle → en=1, addr=8, data=0xDEADBEEF.
- r0 suppression: RegWrite=1, rd=0 → en=0 while retired still increments.
- Stall: load with rd=9 enters WB, stall held 3 cycles, mem_data changes from 0xA5A5_A5A5 to 0x0 after the first stall cycle → en=0 for 3 cycles, then en=1 with data=0xA5A5A5A5; stall_count=3, retired=1.
- Flush with stall: valid instruction in WB, stall=1 and flush=1 for one cycle → en=0 throughout, valid_q=0 afterwards, retired unchanged.
- Reset mid-operation: drop rst_n during a held stall → all outputs and counters read 0 immediately, without waiting for clk.
